// File: rtl/taillight_scheduler.sv
// -----------------------------------------------------------------------------
// taillight_scheduler
//
// Front-end sequencer for the sequential taillight controller. It synchronizes
// and debounces the raw driver switches and resolves them into one lighting
// mode. It also generates the sequence step strobe and the dimming clock.
// Turn/hazard mode changes only take effect on a sequence-frame boundary, so a
// running sweep is never cut off mid-pattern. Brake is not held to the frame
// rule and follows its debounced input every cycle.
//
// Optional feature macro: TAILLIGHT_SCHED_DEBOUNCE_EN
//   defined   : a per-input counter accepts a change only after DEB_CYCLES
//               consecutive cycles of disagreement.
//   undefined : the debounced value is the synchronizer output and no
//               debounce counters exist.
//
// Parameters:
//   TICK_DIV   clk cycles per sequence step (>= 2)
//   DEB_CYCLES stable cycles needed to accept a switch change (>= 1)
//   DIM_DIV    dim_clk period in clk cycles (even, >= 2)
//
// Ports:
//   clk                                   system clock, rising edge
//   rst                                   asynchronous active-high reset
//   left_sw, right_sw, brake_sw, hazard_sw raw asynchronous switches
//   step_en                               one-cycle pulse per sequence step
//   dim_clk                               dimming square wave
//   left, right, hazard                   registered mode command (one-hot or 0)
//   brake                                 registered debounced brake
//   phase[1:0]                            step index within frame (0..3)
//   pending                               mode change waiting for frame boundary
// -----------------------------------------------------------------------------
module taillight_scheduler #(
  parameter int TICK_DIV   = 12500000,
  parameter int DEB_CYCLES = 16,
  parameter int DIM_DIV    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       left_sw,
  input  logic       right_sw,
  input  logic       brake_sw,
  input  logic       hazard_sw,
  output logic       step_en,
  output logic       dim_clk,
  output logic       left,
  output logic       right,
  output logic       hazard,
  output logic       brake,
  output logic [1:0] phase,
  output logic       pending
);

  localparam int STEP_W = $clog2(TICK_DIV);
  localparam int DIM_W  = $clog2(DIM_DIV);

  // Bit positions of the switches inside the packed input vectors.
  localparam int IDX_L = 0;
  localparam int IDX_R = 1;
  localparam int IDX_B = 2;
  localparam int IDX_H = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEFT,
    ST_RIGHT,
    ST_HAZARD
  } mode_t;

  // Elaboration-time parameter sanity checks.
  if (TICK_DIV < 2) begin : g_bad_tick
    $error("taillight_scheduler: TICK_DIV must be >= 2");
  end
  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("taillight_scheduler: DEB_CYCLES must be >= 1");
  end
  if ((DIM_DIV < 2) || (DIM_DIV % 2 != 0)) begin : g_bad_dim
    $error("taillight_scheduler: DIM_DIV must be even and >= 2");
  end

  // ---------------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------------
  logic [3:0] raw;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] deb;

  assign raw = {hazard_sw, brake_sw, right_sw, left_sw};

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce
  // ---------------------------------------------------------------------------
`ifdef TAILLIGHT_SCHED_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  logic [DEB_W-1:0] deb_cnt [4];

  // The counter runs only while the synchronized input disagrees with the
  // accepted value. Any agreement restarts it, so short glitches are dropped.
  // NOTE: the counter array is reset explicitly. These are a few control
  // flops, not a RAM, and an unreset count could accept a bogus edge after
  // reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb <= '0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end
`else
  assign deb = sync2;
`endif

  // ---------------------------------------------------------------------------
  // Request resolve: hazard wins, and both turn switches together mean hazard.
  // ---------------------------------------------------------------------------
  mode_t request;

  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    request = ST_IDLE;
    if (deb[IDX_H])                      request = ST_HAZARD;
    else if (deb[IDX_L] && deb[IDX_R])   request = ST_HAZARD;
    else if (deb[IDX_L])                 request = ST_LEFT;
    else if (deb[IDX_R])                 request = ST_RIGHT;
  end

  // ---------------------------------------------------------------------------
  // Step strobe and dimming clock
  // ---------------------------------------------------------------------------
  logic [STEP_W-1:0] step_cnt;
  logic [DIM_W-1:0]  dim_cnt;

  assign step_en = (step_cnt == STEP_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt <= '0;
      dim_cnt  <= '0;
      dim_clk  <= 1'b0;
    end else begin
      step_cnt <= step_en ? '0 : step_cnt + STEP_W'(1);
      dim_cnt  <= (dim_cnt == DIM_W'(DIM_DIV - 1)) ? '0 : dim_cnt + DIM_W'(1);
      // Registered decode of the current count; high for the first half period.
      dim_clk  <= (dim_cnt < DIM_W'(DIM_DIV / 2));
    end
  end

  // ---------------------------------------------------------------------------
  // Mode FSM
  // ---------------------------------------------------------------------------
  mode_t      state;
  mode_t      state_next;
  logic [1:0] phase_next;

  always_comb begin
    state_next = state;
    phase_next = phase;
    if (step_en) begin
      if (state == ST_IDLE) begin
        // Leaving IDLE starts a fresh frame at phase 0.
        state_next = request;
        phase_next = 2'd0;
      end else begin
        phase_next = phase + 2'd1;
        // Only the request seen at the frame-closing step counts.
        if ((phase == 2'd3) && (request != state)) state_next = request;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      phase  <= 2'd0;
      left   <= 1'b0;
      right  <= 1'b0;
      hazard <= 1'b0;
      brake  <= 1'b0;
    end else begin
      state  <= state_next;
      phase  <= phase_next;
      left   <= (state_next == ST_LEFT);
      right  <= (state_next == ST_RIGHT);
      hazard <= (state_next == ST_HAZARD);
      brake  <= deb[IDX_B];
    end
  end

  assign pending = (request != state);

endmodule

// File: tb/tb_taillight_scheduler.sv
// -----------------------------------------------------------------------------
// tb_taillight_scheduler
//
// Self-checking bench for taillight_scheduler with TICK_DIV=4, DEB_CYCLES=3 and
// DIM_DIV=4. Stimulus code pushes each expected value, tagged with the cycle
// it is due, into a scoreboard queue. A negedge monitor pops each entry when
// its cycle is reached and compares it with the DUT output. Input-to-debounced
// latency follows TAILLIGHT_SCHED_DEBOUNCE_EN.
// -----------------------------------------------------------------------------
module tb_taillight_scheduler;

  localparam int TICK = 4;
  localparam int DEB  = 3;
  localparam int DIM  = 4;
`ifdef TAILLIGHT_SCHED_DEBOUNCE_EN
  localparam int DL = 2 + DEB;
`else
  localparam int DL = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       left_sw = 1'b0;
  logic       right_sw = 1'b0;
  logic       brake_sw = 1'b0;
  logic       hazard_sw = 1'b0;
  logic       step_en;
  logic       dim_clk;
  logic       left;
  logic       right;
  logic       hazard;
  logic       brake;
  logic [1:0] phase;
  logic       pending;

  taillight_scheduler #(
    .TICK_DIV  (TICK),
    .DEB_CYCLES(DEB),
    .DIM_DIV   (DIM)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .left_sw  (left_sw),
    .right_sw (right_sw),
    .brake_sw (brake_sw),
    .hazard_sw(hazard_sw),
    .step_en  (step_en),
    .dim_clk  (dim_clk),
    .left     (left),
    .right    (right),
    .hazard   (hazard),
    .brake    (brake),
    .phase    (phase),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit done     = 1'b0;

  typedef enum {O_STEP, O_DIM, O_LEFT, O_RIGHT, O_HAZ, O_BRAKE, O_PHASE, O_PEND} obs_t;

  typedef struct {
    int    due;
    obs_t  sig;
    int    exp;
    string tag;
  } sb_t;

  sb_t sb[$];

  // Cycle index: number of rising edges since reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] sample(input obs_t s);
    case (s)
      O_STEP:  return 32'(step_en);
      O_DIM:   return 32'(dim_clk);
      O_LEFT:  return 32'(left);
      O_RIGHT: return 32'(right);
      O_HAZ:   return 32'(hazard);
      O_BRAKE: return 32'(brake);
      O_PHASE: return 32'(phase);
      O_PEND:  return 32'(pending);
      default: return 32'hffff_ffff;
    endcase
  endfunction

  task automatic sb_push(input int due, input obs_t s, input int exp, input string tag);
    sb_t e;
    e.due = due;
    e.sig = s;
    e.exp = exp;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // First cycle >= c in which step_en is expected.
  function automatic int next_step(input int c);
    int n = c;
    while (n % TICK != TICK - 1) n++;
    return n;
  endfunction

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Scoreboard monitor: compare every entry due in this cycle, away from posedge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          check(sb[i].tag, sample(sb[i].sig), sb[i].exp);
          sb.delete(i);
        end
      end
    end
  end

  initial begin
    #100000;
    if (!done) begin
      $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
    end
  end

  initial begin
    int s;
    int t;
    int c0;
    int c1;
    int c2;
    int r;
    int t2;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_step_en", 32'(step_en), 0);
    check("rst_dim_clk", 32'(dim_clk), 0);
    check("rst_left",    32'(left),    0);
    check("rst_right",   32'(right),   0);
    check("rst_hazard",  32'(hazard),  0);
    check("rst_brake",   32'(brake),   0);
    check("rst_phase",   32'(phase),   0);
    check("rst_pending", 32'(pending), 0);
    rst = 1'b0;

    // Idle: step_en at cycles 3,7,11,..., dim_clk 1,1,0,0 from cycle 1.
    for (int k = 1; k <= 20; k++) begin
      sb_push(k, O_STEP, (k % TICK == TICK - 1) ? 1 : 0, "idle_step_en");
      sb_push(k, O_DIM, (((k - 1) % DIM) < DIM / 2) ? 1 : 0, "idle_dim_clk");
    end
    sb_push(20, O_LEFT,   0, "idle_left");
    sb_push(20, O_RIGHT,  0, "idle_right");
    sb_push(20, O_HAZ,    0, "idle_hazard");
    sb_push(20, O_PHASE,  0, "idle_phase");
    sb_push(20, O_PEND,   0, "idle_pending");
    sb_push(20, O_BRAKE,  0, "idle_brake");

    // Left turn: taken at first step after debounce, then phase sweeps.
    wait_cyc(20);
    left_sw = 1'b1;
    s = next_step(20 + DL);
    sb_push(s,      O_PEND,  1, "left_pending_before_step");
    sb_push(s,      O_LEFT,  0, "left_before_step");
    sb_push(s + 1,  O_LEFT,  1, "left_taken");
    sb_push(s + 1,  O_PHASE, 0, "left_phase0");
    sb_push(s + 1,  O_PEND,  0, "left_pending_clear");
    sb_push(s + 4,  O_PHASE, 0, "left_phase_hold");
    sb_push(s + 5,  O_PHASE, 1, "left_phase1");
    sb_push(s + 9,  O_PHASE, 2, "left_phase2");
    sb_push(s + 13, O_PHASE, 3, "left_phase3");
    sb_push(s + 17, O_PHASE, 0, "left_phase_wrap");
    sb_push(s + 17, O_LEFT,  1, "left_stays");

    // At phase 1 switch to right: held off until the frame boundary.
    wait_cyc(s + 21);
    left_sw  = 1'b0;
    right_sw = 1'b1;
    sb_push(s + 21 + DL - 1, O_PEND, 0, "l2r_pending_early");
    sb_push(s + 21 + DL,     O_PEND, 1, "l2r_pending");
    sb_push(s + 32, O_LEFT,  1, "l2r_left_held");
    sb_push(s + 32, O_RIGHT, 0, "l2r_right_wait");
    sb_push(s + 32, O_PEND,  1, "l2r_pending_boundary");
    sb_push(s + 33, O_RIGHT, 1, "l2r_right");
    sb_push(s + 33, O_LEFT,  0, "l2r_left_off");
    sb_push(s + 33, O_PHASE, 0, "l2r_phase0");
    sb_push(s + 33, O_PEND,  0, "l2r_pending_clear");

    // Left and right together resolve to hazard.
    wait_cyc(s + 33);
    left_sw = 1'b1;
    sb_push(s + 47, O_PEND,  1, "lr_pending");
    sb_push(s + 48, O_RIGHT, 1, "lr_right_held");
    sb_push(s + 48, O_HAZ,   0, "lr_hazard_wait");
    sb_push(s + 49, O_HAZ,   1, "lr_hazard");
    sb_push(s + 49, O_LEFT,  0, "lr_left_off");
    sb_push(s + 49, O_RIGHT, 0, "lr_right_off");
    sb_push(s + 49, O_PHASE, 0, "lr_phase0");

    // Release everything: back to IDLE at the next boundary.
    wait_cyc(s + 49);
    left_sw  = 1'b0;
    right_sw = 1'b0;
    sb_push(s + 63, O_PEND,  1, "off_pending");
    sb_push(s + 64, O_HAZ,   1, "off_hazard_held");
    sb_push(s + 65, O_HAZ,   0, "off_hazard");
    sb_push(s + 65, O_PHASE, 0, "off_phase0");
    sb_push(s + 65, O_PEND,  0, "off_pending_clear");

    // Hazard switch alone.
    wait_cyc(s + 65);
    hazard_sw = 1'b1;
    t = next_step(s + 65 + DL);
    sb_push(t,     O_PEND,  1, "hz_pending");
    sb_push(t,     O_HAZ,   0, "hz_before_step");
    sb_push(t + 1, O_HAZ,   1, "hz_hazard");
    sb_push(t + 1, O_LEFT,  0, "hz_left_off");
    sb_push(t + 1, O_PHASE, 0, "hz_phase0");

    // Two-cycle brake glitch: filtered with debounce, passed through without.
    c0 = t + 1;
    wait_cyc(c0);
    brake_sw = 1'b1;
    for (int k = 2; k <= 7; k++)
      sb_push(c0 + k, O_BRAKE, (DL == 2 && (k == 3 || k == 4)) ? 1 : 0, "brake_pulse");
    wait_cyc(c0 + 2);
    brake_sw = 1'b0;

    // Held brake appears DL+1 cycles after assertion regardless of phase.
    c1 = c0 + 10;
    wait_cyc(c1);
    brake_sw = 1'b1;
    sb_push(c1 + DL,     O_BRAKE, 0, "brake_hold_early");
    sb_push(c1 + DL + 1, O_BRAKE, 1, "brake_hold");
    sb_push(c1 + DL + 1, O_HAZ,   1, "brake_hazard_kept");
    c2 = c1 + 12;
    wait_cyc(c2);
    brake_sw = 1'b0;
    sb_push(c2 + DL,     O_BRAKE, 1, "brake_release_early");
    sb_push(c2 + DL + 1, O_BRAKE, 0, "brake_release");

    // Reset in HAZARD at phase 2 clears everything at once.
    r = t + 42;
    sb_push(r, O_PHASE, 2, "pre_rst_phase");
    sb_push(r, O_HAZ,   1, "pre_rst_hazard");
    wait_cyc(r);
    #2;
    check("sb_drain_pre_rst", 32'(sb.size()), 0);
    rst = 1'b1;
    #1;
    check("midrst_hazard",  32'(hazard),  0);
    check("midrst_phase",   32'(phase),   0);
    check("midrst_pending", 32'(pending), 0);
    check("midrst_step_en", 32'(step_en), 0);
    check("midrst_dim_clk", 32'(dim_clk), 0);
    @(negedge clk);
    rst = 1'b0;

    // Restart from IDLE with hazard_sw still held.
    t2 = next_step(DL);
    sb_push(1,      O_PHASE, 0, "restart_phase");
    sb_push(1,      O_HAZ,   0, "restart_idle");
    sb_push(3,      O_STEP,  1, "restart_first_step");
    sb_push(t2,     O_HAZ,   0, "restart_hazard_wait");
    sb_push(t2 + 1, O_HAZ,   1, "restart_hazard");
    sb_push(t2 + 1, O_PHASE, 0, "restart_hazard_phase0");
    wait_cyc(t2 + 2);
    check("sb_drain_end", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    done = 1'b1;
    $finish;
  end

endmodule
